// File: rtl/mips_pkg.sv
// Shared pipeline types for the MEM/WB end of the datapath: widths, per-stage
// control bundles and the alignment test used by the memory stage.
package mips_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef struct packed {
        logic memToReg;
        logic regWrite;
        logic memWrite;
        logic memRead;
    } mem_ctrl_t;

    typedef struct packed {
        logic memToReg;
        logic regWrite;
    } wb_ctrl_t;

    // Word accesses only: any nonzero byte offset is a misaligned access.
    function automatic logic isMisaligned(input logic [1:0] byteOffset);
        return byteOffset != 2'b00;
    endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: combinational read, write on the rising edge.
// Contents start at zero and have no reset; write gating lives in the caller.
module data_memory
    import mips_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    localparam int ADDR_BITS = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] memArray [MEM_DEPTH] = '{default: '0};

    // Reading the array before the edge that writes it gives read-before-write.
    assign rdata = memArray[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            memArray[addr] <= wdata;
        end
    end

endmodule

// File: rtl/memory_writeback.sv
// EX/MEM register, data memory access, MEM/WB register and writeback mux.
// Returns the register-file write port and the two forwarding sources.
module memory_writeback
    import mips_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    localparam int ADDR_BITS = $clog2(MEM_DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      memToRegEx,
    input  logic                      regWriteEx,
    input  logic                      memWriteEx,
    input  logic                      memReadEx,
    input  logic [DATA_WIDTH-1:0]     aluResultEx,
    input  logic [DATA_WIDTH-1:0]     memWriteDataEx,
    input  logic [REG_ADDR_WIDTH-1:0] regWriteRegisterEx,
    output logic [DATA_WIDTH-1:0]     aluResultMem,
    output logic                      regWriteMem,
    output logic [REG_ADDR_WIDTH-1:0] writeRegisterMem,
    output logic                      regWriteWb,
    output logic [REG_ADDR_WIDTH-1:0] writeRegisterWb,
    output logic [DATA_WIDTH-1:0]     writeData,
    output logic [DATA_WIDTH-1:0]     regWriteDataWb,
    output logic                      memFault
);

    // There is no valid/ready handshake: one instruction enters per cycle and
    // is never held; a bubble is simply an instruction with all-zero control.

    mem_ctrl_t                 memCtrlMem;
    logic [DATA_WIDTH-1:0]     memWriteDataMem;
    wb_ctrl_t                  wbCtrlWb;
    logic [DATA_WIDTH-1:0]     readDataWb;
    logic [DATA_WIDTH-1:0]     aluResultWb;

    logic [ADDR_BITS-1:0]      wordIndex;
    logic                      misaligned;
    logic                      memWe;
    logic [DATA_WIDTH-1:0]     memRdata;
    logic [DATA_WIDTH-1:0]     readDataMem;

    // EX/MEM register
    always_ff @(posedge clk) begin
        if (reset) begin
            memCtrlMem       <= '0;
            aluResultMem     <= '0;
            memWriteDataMem  <= '0;
            writeRegisterMem <= '0;
        end else begin
            memCtrlMem.memToReg <= memToRegEx;
            memCtrlMem.regWrite <= regWriteEx;
            memCtrlMem.memWrite <= memWriteEx;
            memCtrlMem.memRead  <= memReadEx;
            aluResultMem        <= aluResultEx;
            memWriteDataMem     <= memWriteDataEx;
            writeRegisterMem    <= regWriteRegisterEx;
        end
    end

    assign regWriteMem = memCtrlMem.regWrite;

    // Upper address bits are dropped, so addresses wrap modulo MEM_DEPTH*4.
    assign wordIndex  = aluResultMem[ADDR_BITS+1:2];
    assign misaligned = isMisaligned(aluResultMem[1:0]);
    assign memFault   = (memCtrlMem.memRead | memCtrlMem.memWrite) & misaligned;

    // A store in MEM during a reset cycle belongs to a discarded instruction.
    assign memWe = memCtrlMem.memWrite & ~misaligned & ~reset;

    data_memory #(
        .MEM_DEPTH(MEM_DEPTH)
    ) dataMemory (
        .clk  (clk),
        .we   (memWe),
        .addr (wordIndex),
        .wdata(memWriteDataMem),
        .rdata(memRdata)
    );

    assign readDataMem = misaligned ? '0 : memRdata;

    // MEM/WB register
    always_ff @(posedge clk) begin
        if (reset) begin
            wbCtrlWb        <= '0;
            readDataWb      <= '0;
            aluResultWb     <= '0;
            writeRegisterWb <= '0;
        end else begin
            wbCtrlWb.memToReg <= memCtrlMem.memToReg;
            wbCtrlWb.regWrite <= memCtrlMem.regWrite;
            readDataWb        <= readDataMem;
            aluResultWb       <= aluResultMem;
            writeRegisterWb   <= writeRegisterMem;
        end
    end

    assign writeData      = wbCtrlWb.memToReg ? readDataWb : aluResultWb;
    assign regWriteDataWb = writeData;
    // $zero is hard-wired; the address is still presented for visibility.
    assign regWriteWb     = wbCtrlWb.regWrite & (writeRegisterWb != '0);

endmodule

// File: doc/memory_writeback.md
Name: memory_writeback

Overview:
- Closes the pipeline loop after the execute stage: EX/MEM register, word-addressed data memory, MEM/WB register and writeback mux.
- Consumes the execute-stage outputs (control bits, ALU result, store data, destination register).
- Returns the register-file write port (regWriteWb, writeRegisterWb, writeData) to decode and the forwarding sources (aluResultMem, regWriteDataWb) to execute.

Parameters:
- MEM_DEPTH, 256, number of 32-bit words in data memory (power of two, >= 4).
- ADDR_BITS, $clog2(MEM_DEPTH), word-index width (derived; not overridden).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- memToRegEx  in  1  select memory data for writeback.
- regWriteEx  in  1  instruction writes a register.
- memWriteEx  in  1  store.
- memReadEx  in  1  load.
- aluResultEx  in  32  ALU result / byte address.
- memWriteDataEx  in  32  store data.
- regWriteRegisterEx  in  5  destination register.
- aluResultMem  out  32  EX/MEM ALU result (forwarding source, mux select 2).
- regWriteMem  out  1  EX/MEM regWrite (for the forwarding unit).
- writeRegisterMem  out  5  EX/MEM destination register.
- regWriteWb  out  1  register-file write enable.
- writeRegisterWb  out  5  register-file write address.
- writeData  out  32  register-file write data.
- regWriteDataWb  out  32  same value as writeData (forwarding source, mux select 1).
- memFault  out  1  misaligned access in MEM this cycle.

Behaviour:
- Reset (synchronous, active-high): clears EX/MEM and MEM/WB registers to 0, so every output reads 0 in the cycle after reset. Data memory contents are preserved across reset and are zero at elaboration.
- Reset asserted mid-operation:
  - An in-flight store in MEM in the reset cycle is suppressed (no write).
  - In-flight instructions are discarded.
- EX/MEM register: latches all Ex inputs every rising edge. No stall or flush input; bubbles arrive as all-zero control from execute.
- MEM stage:
  - Word index = aluResultMem[ADDR_BITS+1:2]. Upper address bits are ignored, so addresses wrap modulo MEM_DEPTH*4.
  - Read is combinational from the array; the result is captured into MEM/WB on the next edge.
  - Store is written at the rising edge ending the MEM cycle.
- Simultaneous memRead and memWrite to the same word: read returns the old contents (read-before-write). The store still takes effect.
- Misaligned access: memFault = (memReadMem | memWriteMem) & (aluResultMem[1:0] != 0), combinational.
  - Misaligned store is dropped.
  - Misaligned load returns 0.
  - The instruction otherwise continues normally.
- MEM/WB register: latches memToReg, regWrite, read data, aluResult and destination register.
- Writeback:
  - writeData = memToRegWb ? readDataWb : aluResultWb, combinational from MEM/WB.
  - regWriteDataWb = writeData.
- regWriteWb is forced to 0 when writeRegisterWb == 0; $zero is never written. writeRegisterWb is still driven.
- Latency: inputs presented before edge N appear on Mem outputs after edge N and on Wb outputs after edge N+1.
- Throughput: one instruction per cycle; no back-pressure.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_WIDTH=32 and REG_ADDR_WIDTH=5.
  - Packed struct mem_ctrl_t {memToReg, regWrite, memWrite, memRead}.
  - Packed struct wb_ctrl_t {memToReg, regWrite}.
- Sub-module data_memory (parameter MEM_DEPTH; ports clk, we, addr, wdata, rdata):
  - Combinational read, synchronous write.
  - No reset port; the write-enable gating described above is applied outside it.

Test Plan:
- Store then load: store 0xDEADBEEF to 0x10, then load 0x10 into r8 → two edges after the load enters, regWriteWb=1, writeRegisterWb=8, writeData=0xDEADBEEF.
- ALU writeback: regWrite=1, memToReg=0, aluResult=0x00000007, rd=3 → aluResultMem=7 and regWriteMem=1 after one edge; writeData=regWriteDataWb=7, regWriteWb=1 after two.
- Read/write same word: word 0x20 holds 0x11, then memRead=memWrite=1 with data 0x22 → writeback 0x11; a subsequent load returns 0x22.
- Zero register and wrap: write to rd=0 → regWriteWb=0 with writeRegisterWb=0. Store at address 0x400 (MEM_DEPTH=256) → a load from 0x0 returns the stored value.
- Misaligned: store to 0x13 → memFault=1 for one cycle and no write; load from 0x13 → writeData=0.
- Reset mid-flight: store in MEM coincides with reset=1 → memory unchanged; all outputs 0 next cycle.
